// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: the transmitter state encoding
// and the parity-mode constants selected by the PARITY_ODD parameter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clock cycles within one serial bit and flags the
// last cycle of the bit; 'clear' restarts the count so every state entry begins at zero.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last   = (r_count == CW'(CLKS_PER_BIT - 1));
    assign bit_done = w_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed from a registered-output FIFO: strobes one read, loads the
// character, then shifts start, data (LSB first), optional parity and stop bits out on tx.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_read_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;

    uart_tx_state_t        r_state, w_stateNext;
    logic [DATA_WIDTH-1:0] r_shift, w_shiftNext;
    logic [BW-1:0]         r_bitIdx, w_bitIdxNext;
    logic                  r_parity, w_parityNext;
    logic                  r_tx, w_txNext;
    logic                  w_bitDone;
    logic                  w_baudClear;

    // Counter restarts whenever the state changes, and is held at zero while idle.
    assign w_baudClear = (w_stateNext != r_state) || (r_state == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_baudClear),
        .bit_done(w_bitDone)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitIdx <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_stateNext;
            r_shift  <= w_shiftNext;
            r_bitIdx <= w_bitIdxNext;
            r_parity <= w_parityNext;
            r_tx     <= w_txNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_shiftNext  = r_shift;
        w_bitIdxNext = r_bitIdx;
        w_parityNext = r_parity;
        w_txNext     = 1'b1;

        case (r_state)
            IDLE: begin
                if (!fifo_empty) begin
                    w_stateNext = REQ;
                end
            end
            REQ: begin
                w_stateNext = LOAD;
            end
            LOAD: begin
                w_stateNext  = START;
                w_shiftNext  = fifo_read_data;
                w_parityNext = (^fifo_read_data) ^ (PARITY_ODD == PAR_ODD);
            end
            START: begin
                if (w_bitDone) begin
                    w_stateNext  = DATA;
                    w_bitIdxNext = '0;
                end
            end
            DATA: begin
                if (w_bitDone) begin
                    if (r_bitIdx == BW'(DATA_WIDTH - 1)) begin
                        w_bitIdxNext = '0;
                        w_stateNext  = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 1'b1;
                        w_shiftNext  = r_shift >> 1;
                    end
                end
            end
            PARITY: begin
                if (w_bitDone) begin
                    w_stateNext = STOP;
                end
            end
            STOP: begin
                if (w_bitDone) begin
                    if (r_bitIdx == BW'(STOP_BITS - 1)) begin
                        w_bitIdxNext = '0;
                        w_stateNext  = IDLE;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase

        // tx is registered from the upcoming state so the line changes exactly on state entry.
        case (w_stateNext)
            START:   w_txNext = 1'b0;
            DATA:    w_txNext = w_shiftNext[0];
            PARITY:  w_txNext = r_parity;
            default: w_txNext = 1'b1;
        endcase
    end

    assign tx           = r_tx;
    assign busy         = (r_state != IDLE);
    assign fifo_read_en = (r_state == REQ) && !rst;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (8N1, even parity, odd parity, two stop bits)
// at 4 clocks per bit, each fed by a small behavioural FIFO with a registered output.
module tb_uart_tx;

    logic clk;
    logic rst;

    logic       txA[4];
    logic       busyA[4];
    logic       renA[4];
    logic       emptyA[4];
    logic [7:0] rdData[4];
    logic [7:0] dutData[4];
    logic       clobber[4];

    logic [7:0] fifoMem[4][16];
    int         head[4]      = '{default: 0};
    int         tail[4]      = '{default: 0};
    int         readCount[4] = '{default: 0};

    int checkCount = 0;
    int passCount  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        assign dutData[g] = clobber[g] ? 8'h00 : rdData[g];

        uart_tx #(
            .DATA_WIDTH  (8),
            .CLKS_PER_BIT(4),
            .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD  ((g == 2) ? 1 : 0),
            .STOP_BITS   ((g == 3) ? 2 : 1)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .fifo_empty    (emptyA[g]),
            .fifo_read_data(dutData[g]),
            .fifo_read_en  (renA[g]),
            .tx            (txA[g]),
            .busy          (busyA[g])
        );
    end

    // Behavioural FIFO: output register loads on a sampled read strobe.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            emptyA[i] = (head[i] == tail[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (renA[i]) begin
                readCount[i] <= readCount[i] + 1;
                if (head[i] != tail[i]) begin
                    rdData[i] <= fifoMem[i][head[i]];
                    head[i]   <= head[i] + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] d);
        fifoMem[idx][tail[idx]] = d;
        tail[idx] = tail[idx] + 1;
    endtask

    // Waits (bounded) for the start bit, then records tx once per cycle for len cycles.
    task automatic captureFrame(input int idx, input int len, output logic [63:0] wave,
                                output int waited, output logic busyLast);
        wave   = '0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (txA[idx] !== 1'b0 && waited < 200);
        wave[0] = txA[idx];
        for (int c = 1; c < len; c++) begin
            @(negedge clk);
            wave[c] = txA[idx];
        end
        busyLast = busyA[idx];
    endtask

    function automatic logic [63:0] expWave(input logic [7:0] d, input int parEn,
                                            input int parOdd, input int stops);
        logic [15:0] bits;
        logic [63:0] w;
        int n;
        bits = '0;
        w    = '0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        n = 9;
        if (parEn != 0) begin
            bits[n] = (^d) ^ (parOdd != 0);
            n++;
        end
        for (int s = 0; s < stops; s++) begin
            bits[n] = 1'b1;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < 4; k++) w[b * 4 + k] = bits[b];
        end
        return w;
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] wave;
        int          waited;
        logic        busyLast;
        int          bad;

        for (int i = 0; i < 4; i++) begin
            clobber[i] = 1'b0;
            rdData[i]  = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("resetTx", txA[0], 1'b1);
        checkOutput("resetBusy", busyA[0], 1'b0);
        checkOutput("resetReadEn", renA[0], 1'b0);
        rst = 1'b0;
        $display("[TB] reset released");

        // 8N1, byte 0x55.
        @(negedge clk);
        applyStimulus(0, 8'h55);
        captureFrame(0, 40, wave, waited, busyLast);
        checkOutput("latency55", waited, 3);
        checkOutput("wave55", wave, 64'h0000_00F0_F0F0_F0F0);
        checkOutput("busyLast55", busyLast, 1'b1);
        @(negedge clk);
        checkOutput("busyFall55", busyA[0], 1'b0);
        checkOutput("reads55", readCount[0], 1);

        // Empty FIFO for 100 cycles: no strobes, line idle, not busy.
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (renA[i] !== 1'b0 || txA[i] !== 1'b1 || busyA[i] !== 1'b0) bad++;
            end
        end
        checkOutput("idleBadCycles", bad, 0);
        checkOutput("idleReads", readCount[0], 1);

        // Parity, byte 0x07: even parity bit 1, odd parity bit 0.
        @(negedge clk);
        applyStimulus(1, 8'h07);
        captureFrame(1, 44, wave, waited, busyLast);
        checkOutput("waveEven07", wave, expWave(8'h07, 1, 0, 1));
        checkOutput("parityEven07", wave[37], 1'b1);
        @(negedge clk);
        checkOutput("busyFallEven", busyA[1], 1'b0);

        @(negedge clk);
        applyStimulus(2, 8'h07);
        captureFrame(2, 44, wave, waited, busyLast);
        checkOutput("waveOdd07", wave, expWave(8'h07, 1, 1, 1));
        checkOutput("parityOdd07", wave[37], 1'b0);

        // Two stop bits, back-to-back 0xA5 then 0x3C.
        @(negedge clk);
        applyStimulus(3, 8'hA5);
        applyStimulus(3, 8'h3C);
        captureFrame(3, 44, wave, waited, busyLast);
        checkOutput("waveA5", wave, expWave(8'hA5, 0, 0, 2));
        checkOutput("stopHighA5", wave[43:36], 8'hFF);
        captureFrame(3, 44, wave, waited, busyLast);
        checkOutput("gapB2B", waited, 4);
        checkOutput("wave3C", wave, expWave(8'h3C, 0, 0, 2));
        repeat (4) @(negedge clk);
        checkOutput("reads2Stop", readCount[3], 2);

        // Reset during data bit 3 of 0xFF, then 0x81.
        @(negedge clk);
        applyStimulus(0, 8'hFF);
        captureFrame(0, 18, wave, waited, busyLast);
        checkOutput("partialFF", wave, 64'h3FFF0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midResetTx", txA[0], 1'b1);
        checkOutput("midResetBusy", busyA[0], 1'b0);
        applyStimulus(0, 8'h81);
        captureFrame(0, 40, wave, waited, busyLast);
        checkOutput("wave81", wave, expWave(8'h81, 0, 0, 1));
        checkOutput("reads81", readCount[0], 3);

        // Data register changes after load: output still shows 0xC3.
        repeat (2) @(negedge clk);
        applyStimulus(0, 8'hC3);
        fork
            captureFrame(0, 40, wave, waited, busyLast);
            begin
                repeat (12) @(negedge clk);
                clobber[0] = 1'b1;
            end
        join
        clobber[0] = 1'b0;
        checkOutput("waveC3", wave, expWave(8'hC3, 0, 0, 1));

        // Reset landing on the REQ cycle suppresses the strobe; the byte stays queued.
        repeat (2) @(negedge clk);
        applyStimulus(0, 8'h5A);
        @(negedge clk);
        checkOutput("strobeInReq", renA[0], 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("strobeUnderReset", renA[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("readsAfterReqReset", readCount[0], 4);
        captureFrame(0, 40, wave, waited, busyLast);
        checkOutput("wave5A", wave, expWave(8'h5A, 0, 0, 1));
        checkOutput("readsFinal", readCount[0], 5);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per character.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit, legal range 2 or more.
REQ-003 SHALL have parameter PARITY_EN, default 0, where 1 inserts a parity bit after the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, where 0 is even parity and 1 is odd; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port fifo_empty  input  1  empty flag of the upstream transmit FIFO.
REQ-009 SHALL have port fifo_read_data  input  DATA_WIDTH  FIFO output register, valid the cycle after a read is sampled.
REQ-010 SHALL have port fifo_read_en  output  1  read strobe to the FIFO.
REQ-011 SHALL have port tx  output  1  serial line; idles high.
REQ-012 SHALL have port busy  output  1  high from the REQ state until the last stop bit completes.

Function
REQ-013 SHALL implement states IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
REQ-014 SHALL move from IDLE to REQ when fifo_empty is sampled low, and otherwise stay in IDLE.
REQ-015 SHALL assert fifo_read_en for exactly one cycle while in REQ, and at no other time.
REQ-016 SHALL move from REQ to LOAD unconditionally.
REQ-017 SHALL capture fifo_read_data into a shift register in LOAD, then move to START.
REQ-018 SHALL drive tx low in START for CLKS_PER_BIT cycles, so that tx first falls 3 clock edges after fifo_empty is sampled low in IDLE.
REQ-019 SHALL shift DATA_WIDTH bits out in DATA, LSB first, each held for exactly CLKS_PER_BIT cycles.
REQ-020 SHALL go from DATA to PARITY only when PARITY_EN=1, otherwise directly to STOP.
REQ-021 SHALL drive tx in PARITY to the XOR of the data bits when PARITY_ODD=0, or its inverse when PARITY_ODD=1, for CLKS_PER_BIT cycles.
REQ-022 SHALL drive tx high in STOP for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-023 SHALL register tx so that it is glitch-free; tx is high in IDLE, REQ and LOAD.
REQ-024 SHALL, when frames are back-to-back, hold a minimum of 3 idle-high cycles between a stop bit's end and the next start bit (IDLE, REQ, LOAD).
REQ-025 SHALL size the baud counter at $clog2(CLKS_PER_BIT) bits, count 0 to CLKS_PER_BIT-1, and restart at 0 on every state entry.
REQ-026 SHALL size the bit index at $clog2(DATA_WIDTH)+1 bits, and never wrap past DATA_WIDTH-1.
REQ-027 SHALL NOT read the FIFO while in any state other than IDLE, whatever fifo_empty does.
REQ-028 SHALL leave the captured data unaffected by fifo_read_data changes after LOAD.

Reset
REQ-029 SHALL, on rst high at a clock edge, enter IDLE with tx=1, fifo_read_en=0, busy=0, counters=0 and the shift register=0.
REQ-030 SHALL, when rst occurs mid-frame, force tx high on the next edge and discard the in-flight character, with no retry.
REQ-031 SHALL give rst priority over every state transition, including the REQ strobe, so that fifo_read_en=0 in the reset cycle.

Structure
REQ-032 SHALL place the state enum typedef (uart_tx_state_t) and the parity-mode constants in shared package uart_pkg.
REQ-033 SHALL factor the baud counter into one sub-module, uart_baud_gen, with inputs clk, rst and clear, and output bit_done (pulses on the last cycle of a bit).
REQ-034 SHALL keep all other logic in uart_tx, with no combinational path from fifo_empty to fifo_read_en.

Verification
REQ-035 SHALL cover: CLKS_PER_BIT=4, 8N1, FIFO holds 0x55 -> one read strobe; tx = 0,1,0,1,0,1,0,1,0,1 at 4 cycles per bit (40 cycles); busy then falls.
REQ-036 SHALL cover: PARITY_EN=1, even parity, byte 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame length 44 cycles.
REQ-037 SHALL cover: STOP_BITS=2, bytes 0xA5 then 0x3C queued -> two frames; stop high for 8 cycles plus 3 idle cycles; exactly two read strobes.
REQ-038 SHALL cover: fifo_empty held high for 100 cycles -> fifo_read_en never asserted; tx=1 and busy=0 throughout.
REQ-039 SHALL cover: rst asserted during data bit 3 of 0xFF -> tx=1 on the next edge; IDLE; a following byte 0x81 transmits correctly.
REQ-040 SHALL cover: fifo_read_data changed to 0x00 during DATA after loading 0xC3 -> the serial output still shows 0xC3.
